lamp_sequence_monitor: RTL and testbench

LAMP_SEQUENCE_MONITOR -- requirements
Module: lamp_sequence_monitor

---
 rtl/lamp_pkg.sv | 44 ++++
 rtl/lamp_sequence_monitor_if.sv | 38 +++
 rtl/lamp_dwell_counter.sv | 46 ++++
 rtl/lamp_sequence_monitor.sv | 137 +++++++++++++
 tb/tb_lamp_sequence_monitor.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp sequence monitor and the upstream lamp sequencer.
// Holds the one-hot lamp codes, the fault cause codes, the monitor state encoding,
// the dwell counter operation select, and the legality helpers.
package lamp_pkg;

  localparam logic [2:0] LampOff    = 3'b000;
  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampGreen  = 3'b010;
  localparam logic [2:0] LampYellow = 3'b001;

  typedef enum logic [1:0] {
    FaultNone       = 2'b00,
    FaultEncoding   = 2'b01,
    FaultTransition = 2'b10,
    FaultTimeout    = 2'b11
  } fault_code_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFault = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DwellHold  = 2'b00,
    DwellClear = 2'b01,
    DwellLoad  = 2'b10,
    DwellInc   = 2'b11
  } dwell_op_e;

  // Exactly one of the three lamp codes. An X input evaluates non-true, so callers
  // must branch on the positive result to treat X as illegal.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == LampRed) || (code == LampGreen) || (code == LampYellow);
  endfunction

  // Legal forward step between two different legal codes.
  function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return ((prev == LampGreen)  && (cur == LampYellow)) ||
           ((prev == LampYellow) && (cur == LampRed))    ||
           ((prev == LampRed)    && (cur == LampGreen));
  endfunction

endpackage

// File: rtl/lamp_sequence_monitor_if.sv
// Bus between the lamp sequencer side (master) and the monitor (slave).
//   lamp        : one-hot lamp code from the sequencer
//   clear_fault : single-cycle request to leave FAULT
//   walk / dont_walk, fault, fault_code, cycle_count, dwell : registered monitor outputs
interface lamp_sequence_monitor_if;

  logic [2:0] lamp;
  logic       clear_fault;
  logic       walk;
  logic       dont_walk;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] cycle_count;
  logic [7:0] dwell;

  modport master (
    output lamp,
    output clear_fault,
    input  walk,
    input  dont_walk,
    input  fault,
    input  fault_code,
    input  cycle_count,
    input  dwell
  );

  modport slave (
    input  lamp,
    input  clear_fault,
    output walk,
    output dont_walk,
    output fault,
    output fault_code,
    output cycle_count,
    output dwell
  );

endinterface

// File: rtl/lamp_dwell_counter.sv
// Saturating count of cycles the current lamp code has been held.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, clears the count
//   op_i      : hold / clear to 0 / load 1 / increment (saturating at 255)
//   dwell_o   : current count
//   timeout_o : the next increment would reach MAX_DWELL
module lamp_dwell_counter
  import lamp_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 200
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  dwell_op_e op_i,
  output logic [7:0] dwell_o,
  output logic      timeout_o
);

  logic [7:0] dwell_q, dwell_d;
  logic [8:0] dwell_inc;

  // Nine bits so the compare against MAX_DWELL cannot alias at 255 + 1.
  assign dwell_inc = {1'b0, dwell_q} + 9'd1;
  assign timeout_o = (dwell_inc == 9'(MAX_DWELL));
  assign dwell_o   = dwell_q;

  always_comb begin
    dwell_d = dwell_q;
    unique case (op_i)
      DwellHold:  dwell_d = dwell_q;
      DwellClear: dwell_d = 8'd0;
      DwellLoad:  dwell_d = 8'd1;
      DwellInc:   dwell_d = dwell_inc[8] ? 8'hff : dwell_inc[7:0];
      default:    dwell_d = dwell_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= 8'd0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Watches the one-hot lamp code from the upstream sequencer, drives the pedestrian
// WALK / DON'T WALK outputs and latches the first fault cause (bad encoding, bad
// transition, dwell timeout) until cleared.
//   clock_i : clock
//   reset_i : synchronous active-high reset
//   bus_io  : slave side of lamp_sequence_monitor_if (lamp/clear_fault in, status out)
module lamp_sequence_monitor
  import lamp_pkg::*;
#(
  parameter int unsigned MAX_DWELL = 200
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  lamp_sequence_monitor_if.slave  bus_io
);

  state_e      state_q, state_d;
  logic [2:0]  prev_lamp_q, prev_lamp_d;
  logic        walk_q, walk_d;
  logic        dont_walk_q, dont_walk_d;
  logic        fault_q, fault_d;
  fault_code_e fault_code_q, fault_code_d;
  logic [7:0]  cycle_count_q, cycle_count_d;

  dwell_op_e   dwell_op;
  logic [7:0]  dwell;
  logic        dwell_timeout;
  logic [2:0]  lamp;

  assign lamp = bus_io.lamp;

  lamp_dwell_counter #(
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .op_i      (dwell_op),
    .dwell_o   (dwell),
    .timeout_o (dwell_timeout)
  );

  always_comb begin
    state_d       = state_q;
    prev_lamp_d   = prev_lamp_q;
    walk_d        = 1'b0;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    cycle_count_d = cycle_count_q;
    dwell_op      = DwellHold;

    unique case (state_q)
      StIdle: begin
        if (is_legal_code(lamp)) begin
          state_d     = StRun;
          prev_lamp_d = lamp;
          dwell_op    = DwellLoad;
          walk_d      = (lamp == LampRed);
        end
      end

      StRun: begin
        // Positive test first so an X lamp lands in the encoding-fault branch.
        if (is_legal_code(lamp)) begin
          if (lamp == prev_lamp_q) begin
            if (dwell_timeout) begin
              state_d      = StFault;
              fault_d      = 1'b1;
              fault_code_d = FaultTimeout;
            end else begin
              dwell_op = DwellInc;
              walk_d   = (lamp == LampRed);
            end
          end else if (is_legal_step(prev_lamp_q, lamp)) begin
            prev_lamp_d = lamp;
            dwell_op    = DwellLoad;
            walk_d      = (lamp == LampRed);
            if (prev_lamp_q == LampYellow) begin
              cycle_count_d = cycle_count_q + 8'd1;
            end
          end else begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_code_d = FaultTransition;
          end
        end else begin
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_code_d = FaultEncoding;
        end
      end

      StFault: begin
        // Lamp is ignored here; only clear_fault leaves.
        if (bus_io.clear_fault) begin
          state_d      = StIdle;
          fault_d      = 1'b0;
          fault_code_d = FaultNone;
          dwell_op     = DwellClear;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    dont_walk_d = ~walk_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      prev_lamp_q   <= LampOff;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      fault_q       <= 1'b0;
      fault_code_q  <= FaultNone;
      cycle_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      prev_lamp_q   <= prev_lamp_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus_io.walk        = walk_q;
  assign bus_io.dont_walk   = dont_walk_q;
  assign bus_io.fault       = fault_q;
  assign bus_io.fault_code  = fault_code_q;
  assign bus_io.cycle_count = cycle_count_q;
  assign bus_io.dwell       = dwell;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor with MAX_DWELL=4.
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] G   = 3'b010;
  localparam logic [2:0] Y   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lamp_sequence_monitor_if bus ();

  lamp_sequence_monitor #(
    .MAX_DWELL (4)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus_io  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs; dont_walk is expected to be the inverse of walk.
  task automatic expect_all(input string tag, input logic w, input logic f,
                            input logic [1:0] code, input logic [7:0] cc,
                            input logic [7:0] dw);
    chk($sformatf("%s.walk", tag), {7'd0, bus.walk}, {7'd0, w});
    chk($sformatf("%s.dont_walk", tag), {7'd0, bus.dont_walk}, {7'd0, ~w});
    chk($sformatf("%s.fault", tag), {7'd0, bus.fault}, {7'd0, f});
    chk($sformatf("%s.code", tag), {6'd0, bus.fault_code}, {6'd0, code});
    chk($sformatf("%s.cycles", tag), bus.cycle_count, cc);
    chk($sformatf("%s.dwell", tag), bus.dwell, dw);
  endtask

  task automatic step(input logic [2:0] l, input logic clr, input logic r);
    bus.lamp        = l;
    bus.clear_fault = clr;
    rst             = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.lamp        = 3'bxxx;
    bus.clear_fault = 1'b0;

    // Reset state, then IDLE ignores unknown and 000.
    step(3'bxxx, 1'b0, 1'b1);
    expect_all("reset", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    step(3'bxxx, 1'b0, 1'b0);
    expect_all("idle_x", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    step(OFF, 1'b1, 1'b0);
    expect_all("idle_off_clr", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);

    // Three full G,Y,R cycles.
    for (int i = 0; i < 3; i++) begin
      step(G, 1'b0, 1'b0);
      expect_all($sformatf("cyc%0d_g", i), 1'b0, 1'b0, 2'b00, 8'(i), 8'd1);
      step(Y, 1'b0, 1'b0);
      expect_all($sformatf("cyc%0d_y", i), 1'b0, 1'b0, 2'b00, 8'(i), 8'd1);
      step(R, 1'b0, 1'b0);
      expect_all($sformatf("cyc%0d_r", i), 1'b1, 1'b0, 2'b00, 8'(i + 1), 8'd1);
    end

    // Dwell timeout on YELLOW hold.
    step(G, 1'b0, 1'b0);
    expect_all("to_g", 1'b0, 1'b0, 2'b00, 8'd3, 8'd1);
    step(Y, 1'b0, 1'b0);
    expect_all("to_y1", 1'b0, 1'b0, 2'b00, 8'd3, 8'd1);
    step(Y, 1'b0, 1'b0);
    expect_all("to_y2", 1'b0, 1'b0, 2'b00, 8'd3, 8'd2);
    step(Y, 1'b0, 1'b0);
    expect_all("to_y3", 1'b0, 1'b0, 2'b00, 8'd3, 8'd3);
    step(Y, 1'b0, 1'b0);
    expect_all("to_fault", 1'b0, 1'b1, 2'b11, 8'd3, 8'd3);
    step(G, 1'b0, 1'b0);
    expect_all("to_sticky", 1'b0, 1'b1, 2'b11, 8'd3, 8'd3);

    // Clear with GREEN present: lamp ignored, then RUN next cycle.
    step(G, 1'b1, 1'b0);
    expect_all("clr_idle", 1'b0, 1'b0, 2'b00, 8'd3, 8'd0);
    step(G, 1'b0, 1'b0);
    expect_all("clr_run", 1'b0, 1'b0, 2'b00, 8'd3, 8'd1);
    step(Y, 1'b1, 1'b0);
    expect_all("clr_in_run", 1'b0, 1'b0, 2'b00, 8'd3, 8'd1);

    // Illegal transition GREEN -> RED.
    step(R, 1'b0, 1'b0);
    expect_all("tr_r", 1'b1, 1'b0, 2'b00, 8'd4, 8'd1);
    step(G, 1'b0, 1'b0);
    expect_all("tr_g", 1'b0, 1'b0, 2'b00, 8'd4, 8'd1);
    step(R, 1'b0, 1'b0);
    expect_all("tr_fault", 1'b0, 1'b1, 2'b10, 8'd4, 8'd1);
    step(G, 1'b0, 1'b0);
    expect_all("tr_sticky_g", 1'b0, 1'b1, 2'b10, 8'd4, 8'd1);
    step(Y, 1'b0, 1'b0);
    expect_all("tr_sticky_y", 1'b0, 1'b1, 2'b10, 8'd4, 8'd1);

    // Illegal encoding, then encoding beats a pending timeout.
    step(OFF, 1'b1, 1'b0);
    expect_all("enc_clr", 1'b0, 1'b0, 2'b00, 8'd4, 8'd0);
    step(G, 1'b0, 1'b0);
    expect_all("enc_g", 1'b0, 1'b0, 2'b00, 8'd4, 8'd1);
    step(3'b011, 1'b0, 1'b0);
    expect_all("enc_fault", 1'b0, 1'b1, 2'b01, 8'd4, 8'd1);
    step(OFF, 1'b1, 1'b0);
    expect_all("enc_clr2", 1'b0, 1'b0, 2'b00, 8'd4, 8'd0);
    step(OFF, 1'b0, 1'b0);
    expect_all("enc_idle", 1'b0, 1'b0, 2'b00, 8'd4, 8'd0);
    step(Y, 1'b0, 1'b0);
    step(Y, 1'b0, 1'b0);
    step(Y, 1'b0, 1'b0);
    expect_all("prio_y3", 1'b0, 1'b0, 2'b00, 8'd4, 8'd3);
    step(3'b101, 1'b0, 1'b0);
    expect_all("prio_fault", 1'b0, 1'b1, 2'b01, 8'd4, 8'd3);
    step(3'b111, 1'b1, 1'b0);
    expect_all("prio_clr", 1'b0, 1'b0, 2'b00, 8'd4, 8'd0);

    // Reset mid-run with cycle_count=5.
    step(G, 1'b0, 1'b0);
    step(Y, 1'b0, 1'b0);
    step(R, 1'b0, 1'b0);
    expect_all("rst_pre", 1'b1, 1'b0, 2'b00, 8'd5, 8'd1);
    step(G, 1'b0, 1'b1);
    expect_all("rst_run", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(OFF, 1'b0, 1'b0);
      expect_all($sformatf("rst_off%0d", i), 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    end
    step(R, 1'b0, 1'b0);
    expect_all("rst_red_entry", 1'b1, 1'b0, 2'b00, 8'd0, 8'd1);

    // Reset while in FAULT leaves no residue.
    step(Y, 1'b0, 1'b0);
    expect_all("rstf_fault", 1'b0, 1'b1, 2'b10, 8'd0, 8'd1);
    step(G, 1'b0, 1'b1);
    expect_all("rstf_reset", 1'b0, 1'b0, 2'b00, 8'd0, 8'd0);
    step(G, 1'b0, 1'b0);
    expect_all("rstf_run", 1'b0, 1'b0, 2'b00, 8'd0, 8'd1);
    step(Y, 1'b0, 1'b0);
    expect_all("rstf_y", 1'b0, 1'b0, 2'b00, 8'd0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
